// File: rtl/mcp4921_spi_tx.sv
// mcp4921_spi_tx
// Frames 12-bit DAC codes into 16-bit MCP4921 write commands and shifts them
// out in SPI mode 0,0, followed by an LDAC strobe. A one-entry pending buffer
// holds the newest sample that arrives while a write is in progress.
module mcp4921_spi_tx #(
    parameter int unsigned CLK_DIV = 4,     // sck half-period in clk cycles
    parameter logic        BUF     = 1'b0,  // VREF buffer enable (frame bit 14)
    parameter logic        GAIN_1X = 1'b1,  // GA_n (frame bit 13)
    parameter logic        SHDN_N  = 1'b1   // active output (frame bit 12)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] sample,
    output logic        sck,
    output logic        sdi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        done
);

    localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_CS_HOLD,
        S_LDAC
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      frame_q, frame_d;
    logic [11:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic             cs_n_q, cs_n_d;
    logic             ldac_n_q, ldac_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             phase_last;
    logic [3:0]       bit_dec;

    // Command word: write to DAC A, then the three configuration bits.
    function automatic logic [15:0] build_frame(input logic [11:0] code);
        return {1'b0, BUF, GAIN_1X, SHDN_N, code};
    endfunction

    assign phase_last = (cnt_q == CNT_LAST);
    assign bit_dec    = bit_q - 4'd1;

    // Next-state, next-output and pending-buffer logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        frame_d    = frame_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sck_d      = sck_q;
        sdi_d      = sdi_q;
        cs_n_d     = cs_n_q;
        ldac_n_d   = ldac_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Any request that arrives mid-write replaces the buffered one.
        if (start && (state_q != S_IDLE)) begin
            pend_d     = sample;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    frame_d = build_frame(sample);
                    state_d = S_CS_SETUP;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    sdi_d   = frame_d[15];
                    busy_d  = 1'b1;
                end
            end
            S_CS_SETUP: begin
                if (phase_last) begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = '0;
                    bit_d   = 4'd15;
                    sdi_d   = frame_q[15];
                end
            end
            S_SHIFT_LO: begin
                if (phase_last) begin
                    state_d = S_SHIFT_HI;
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (phase_last) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        state_d = S_CS_HOLD;
                    end else begin
                        state_d = S_SHIFT_LO;
                        bit_d   = bit_dec;
                        sdi_d   = frame_q[bit_dec];
                    end
                end
            end
            S_CS_HOLD: begin
                if (phase_last) begin
                    state_d  = S_LDAC;
                    cnt_d    = '0;
                    cs_n_d   = 1'b1;
                    ldac_n_d = 1'b0;
                end
            end
            S_LDAC: begin
                if (phase_last) begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    ldac_n_d = 1'b1;
                    // A start on this very edge counts as pending and wins.
                    if (start || pend_vld_q) begin
                        frame_d    = build_frame(start ? sample : pend_q);
                        pend_vld_d = 1'b0;
                        state_d    = S_CS_SETUP;
                        cs_n_d     = 1'b0;
                        sck_d      = 1'b0;
                        sdi_d      = frame_d[15];
                        busy_d     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        sck_d   = 1'b0;
                        sdi_d   = 1'b0;
                        cs_n_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            pend_vld_q <= 1'b0;
            sck_q      <= 1'b0;
            sdi_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            ldac_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            pend_vld_q <= pend_vld_d;
            sck_q      <= sck_d;
            sdi_q      <= sdi_d;
            cs_n_q     <= cs_n_d;
            ldac_n_q   <= ldac_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Frame shift data and buffered sample; qualified by the control state.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
        pend_q  <= pend_d;
    end

    assign sck    = sck_q;
    assign sdi    = sdi_q;
    assign cs_n   = cs_n_q;
    assign ldac_n = ldac_n_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mcp4921_spi_tx.sv
// tb_mcp4921_spi_tx
// Directed bench for mcp4921_spi_tx: one instance at CLK_DIV=4 with default
// configuration bits and one at CLK_DIV=1, BUF=1, GAIN_1X=0. A small SPI
// slave model captures the bits shifted on rising sck while cs_n is low.
module tb_mcp4921_spi_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic [11:0] sample;
    logic        start0, start1;

    logic sck0, sdi0, cs_n0, ldac_n0, busy0, done0;
    logic sck1, sdi1, cs_n1, ldac_n1, busy1, done1;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    mcp4921_spi_tx #(.CLK_DIV(4), .BUF(1'b0), .GAIN_1X(1'b1), .SHDN_N(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .sample(sample),
        .sck(sck0), .sdi(sdi0), .cs_n(cs_n0), .ldac_n(ldac_n0),
        .busy(busy0), .done(done0)
    );

    mcp4921_spi_tx #(.CLK_DIV(1), .BUF(1'b1), .GAIN_1X(1'b0), .SHDN_N(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sample(sample),
        .sck(sck1), .sdi(sdi1), .cs_n(cs_n1), .ldac_n(ldac_n1),
        .busy(busy1), .done(done1)
    );

    // Observed instance
    logic sck_m, sdi_m, cs_n_m, ldac_n_m, busy_m, done_m;
    assign sck_m    = sel ? sck1    : sck0;
    assign sdi_m    = sel ? sdi1    : sdi0;
    assign cs_n_m   = sel ? cs_n1   : cs_n0;
    assign ldac_n_m = sel ? ldac_n1 : ldac_n0;
    assign busy_m   = sel ? busy1   : busy0;
    assign done_m   = sel ? done1   : done0;

    // SPI slave model, sampled away from the active clock edge
    int          cyc = 0;
    logic [15:0] m_cap = 16'h0;
    int          m_edges = 0, m_hi = 0, m_first = 0, m_last = 0;
    logic [15:0] frames [16];
    int          fcount = 0;
    int          sdi_bad = 0, done_tot = 0, ldac_pulses = 0;
    logic        cs_prev = 1'b1, sck_prev = 1'b0, sdi_prev = 1'b0, ldac_prev = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cs_prev && !cs_n_m) begin
            m_cap = 16'h0; m_edges = 0; m_hi = 0; m_first = 0; m_last = 0;
        end
        if (!cs_n_m && sck_m) m_hi = m_hi + 1;
        if (!cs_n_m && sck_m && !sck_prev) begin
            m_cap   = {m_cap[14:0], sdi_m};
            m_edges = m_edges + 1;
            if (m_edges == 1) m_first = cyc;
            m_last = cyc;
            if (m_edges == 16) begin
                frames[fcount % 16] = m_cap;
                fcount = fcount + 1;
            end
        end
        if (sck_m && (sdi_m !== sdi_prev)) sdi_bad = sdi_bad + 1;
        if (done_m) done_tot = done_tot + 1;
        if (ldac_prev && !ldac_n_m) ldac_pulses = ldac_pulses + 1;
        cs_prev   = cs_n_m;
        sck_prev  = sck_m;
        sdi_prev  = sdi_m;
        ldac_prev = ldac_n_m;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".sck"},    32'(sck_m),    32'd0);
        chk({tag, ".sdi"},    32'(sdi_m),    32'd0);
        chk({tag, ".cs_n"},   32'(cs_n_m),   32'd1);
        chk({tag, ".ldac_n"}, 32'(ldac_n_m), 32'd1);
        chk({tag, ".busy"},   32'(busy_m),   32'd0);
        chk({tag, ".done"},   32'(done_m),   32'd0);
    endtask

    // Per-write observations
    int   w_cs_lo, w_ld_lo, w_bsy, w_dn, w_dn_at, w_dn2_at;
    logic w_bsy_at_dn, w_cs_at_dn;

    // Accept s0 on the next edge, then watch n cycles; j1/j2 inject extra starts.
    task automatic watch(input logic [11:0] s0, input int n,
                         input int j1, input logic [11:0] s1,
                         input int j2, input logic [11:0] s2);
        w_cs_lo = 0; w_ld_lo = 0; w_bsy = 0; w_dn = 0; w_dn_at = 0; w_dn2_at = 0;
        w_bsy_at_dn = 1'bx; w_cs_at_dn = 1'bx;
        @(negedge clk); #1;
        start = 1'b1; sample = s0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (!cs_n_m)   w_cs_lo++;
            if (!ldac_n_m) w_ld_lo++;
            if (busy_m)    w_bsy++;
            if (done_m) begin
                w_dn++;
                if (w_dn == 1) begin
                    w_dn_at = j; w_bsy_at_dn = busy_m; w_cs_at_dn = cs_n_m;
                end else begin
                    w_dn2_at = j;
                end
            end
            if (j == j1) begin start = 1'b1; sample = s1; end
            if (j == j2) begin start = 1'b1; sample = s2; end
        end
    endtask

    int fb, dtot, lp, cs_cnt;

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; sample = 12'h000;

        // Reset values
        repeat (3) @(negedge clk);
        #1 chk_idle("reset_init");
        @(negedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_idle("reset_idle");
        @(negedge clk); #1 reset = 1'b0;

        // Single write at H=4
        fb = fcount; lp = ldac_pulses;
        watch(12'hA5C, 160, 0, 12'h000, 0, 12'h000);
        chk("single.nframes", 32'(fcount - fb), 32'd1);
        chk("single.frame",   32'(frames[fb % 16]), 32'h3A5C);
        chk("single.cs_lo",   32'(w_cs_lo), 32'd136);
        chk("single.ldac_lo", 32'(w_ld_lo), 32'd4);
        chk("single.busy",    32'(w_bsy),   32'd140);
        chk("single.ndone",   32'(w_dn),    32'd1);
        chk("single.done_at", 32'(w_dn_at), 32'd141);
        chk("single.busy_at_done", 32'(w_bsy_at_dn), 32'd0);
        chk("single.sck_hi",  32'(m_hi), 32'd64);
        chk("single.sck_span", 32'(m_last - m_first), 32'd120);
        chk("single.ldac_pulses", 32'(ldac_pulses - lp), 32'd1);

        // Back-to-back with pending overwrite
        fb = fcount;
        watch(12'h123, 300, 20, 12'h456, 50, 12'h789);
        chk("b2b.nframes", 32'(fcount - fb), 32'd2);
        chk("b2b.frame0",  32'(frames[fb % 16]), 32'h3123);
        chk("b2b.frame1",  32'(frames[(fb + 1) % 16]), 32'h3789);
        chk("b2b.ndone",   32'(w_dn),     32'd2);
        chk("b2b.done_at", 32'(w_dn_at),  32'd141);
        chk("b2b.done2_at", 32'(w_dn2_at), 32'd281);
        chk("b2b.busy",    32'(w_bsy),    32'd280);
        chk("b2b.cs_lo",   32'(w_cs_lo),  32'd272);
        chk("b2b.ldac_lo", 32'(w_ld_lo),  32'd8);

        // Start on the same edge that leaves LDAC
        fb = fcount;
        watch(12'h555, 300, 140, 12'h3FF, 0, 12'h000);
        chk("coinc.nframes", 32'(fcount - fb), 32'd2);
        chk("coinc.frame0",  32'(frames[fb % 16]), 32'h3555);
        chk("coinc.frame1",  32'(frames[(fb + 1) % 16]), 32'h33FF);
        chk("coinc.done_at", 32'(w_dn_at), 32'd141);
        chk("coinc.busy_at_done", 32'(w_bsy_at_dn), 32'd1);
        chk("coinc.cs_at_done",   32'(w_cs_at_dn),  32'd0);
        chk("coinc.done2_at", 32'(w_dn2_at), 32'd281);
        chk("coinc.busy",    32'(w_bsy), 32'd280);

        // Reset after the 8th rising sck edge, with a sample pending
        @(negedge clk); #1 start = 1'b1; sample = 12'hABC;
        @(negedge clk); #1 start = 1'b0;
        @(negedge clk); #1 start = 1'b1; sample = 12'h777;
        @(negedge clk); #1 start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_edges == 8) break;
            @(negedge clk); #1;
        end
        chk("midrst.edges", 32'(m_edges), 32'd8);
        #2 reset = 1'b1;
        #1 chk_idle("midrst");
        fb = fcount; dtot = done_tot; lp = ldac_pulses; cs_cnt = 0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!cs_n_m) cs_cnt++;
        end
        chk("midrst.cs_after",  32'(cs_cnt), 32'd0);
        chk("midrst.nframes",   32'(fcount - fb), 32'd0);
        chk("midrst.ndone",     32'(done_tot - dtot), 32'd0);
        chk("midrst.ldac",      32'(ldac_pulses - lp), 32'd0);
        fb = fcount;
        watch(12'h0F0, 160, 0, 12'h000, 0, 12'h000);
        chk("postrst.frame",   32'(frames[fb % 16]), 32'h30F0);
        chk("postrst.nframes", 32'(fcount - fb), 32'd1);
        chk("postrst.ndone",   32'(w_dn), 32'd1);

        // Boundaries at CLK_DIV=1, BUF=1, GAIN_1X=0
        @(negedge clk); #1 sel = 1'b1;
        fb = fcount;
        watch(12'h000, 40, 0, 12'h000, 0, 12'h000);
        chk("h1.frame0",   32'(frames[fb % 16]), 32'h5000);
        chk("h1.busy0",    32'(w_bsy),   32'd35);
        chk("h1.done_at0", 32'(w_dn_at), 32'd36);
        chk("h1.cs_lo0",   32'(w_cs_lo), 32'd34);
        chk("h1.ldac_lo0", 32'(w_ld_lo), 32'd1);
        chk("h1.sck_hi0",  32'(m_hi),    32'd16);
        chk("h1.sck_span0", 32'(m_last - m_first), 32'd30);
        fb = fcount;
        watch(12'hFFF, 40, 0, 12'h000, 0, 12'h000);
        chk("h1.frame1",   32'(frames[fb % 16]), 32'h5FFF);
        chk("h1.busy1",    32'(w_bsy),   32'd35);
        chk("h1.done_at1", 32'(w_dn_at), 32'd36);
        chk("h1.sck_span1", 32'(m_last - m_first), 32'd30);

        chk("sdi_stable_while_sck_high", 32'(sdi_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcp4921_spi_tx.md
# mcp4921_spi_tx

SPI transmitter that writes 12-bit samples to an external MCP4921 DAC. It is the output-side counterpart of the ADC read path: processed samples enter here, are framed into 16-bit MCP4921 write commands, and are shifted out in SPI mode 0,0. After each frame it issues an LDAC pulse. A one-entry pending buffer absorbs a new sample that arrives while a frame is in flight.

## Interface
- CLK_DIV, 4: sck half-period in clk cycles (H); minimum 1
- BUF, 0: frame bit 14, VREF buffer enable
- GAIN_1X, 1: frame bit 13 (GA_n); 1 selects 1x gain
- SHDN_N, 1: frame bit 12; 1 selects active output
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  write request, sampled every clk edge
- sample  input  12  DAC code, captured when start=1
- sck  output  1  SPI clock to DAC
- sdi  output  1  serial data to DAC (MOSI)
- cs_n  output  1  DAC chip select, active low
- ldac_n  output  1  DAC latch strobe, active low
- busy  output  1  frame or LDAC in progress
- done  output  1  one-cycle pulse at end of each write

## Operation
- Frame = {1'b0, BUF, GAIN_1X, SHDN_N, sample[11:0]}, sent MSB first.
- All outputs are registered. Reset values: sck=0, sdi=0, cs_n=1, ldac_n=1, busy=0, done=0. pending_valid=0, FSM=IDLE.
- FSM states:
  - IDLE: outputs at reset values. start=1 loads the frame and moves to CS_SETUP.
  - CS_SETUP: H cycles. cs_n=0, sck=0, sdi=frame[15].
  - SHIFT: 16 bits, i = 15..0. Low phase: H cycles with sck=0, sdi=frame[i] updated on entry. High phase: H cycles with sck=1. The DAC samples on the sck rising edge.
  - CS_HOLD: H cycles. sck=0, cs_n=0.
  - LDAC: H cycles. cs_n=1, ldac_n=0.
  - Exit from LDAC: done=1 for one cycle. If pending_valid, load the pending sample, clear pending_valid, go to CS_SETUP with busy kept high. Otherwise go to IDLE with busy=0.
- start=1 in any non-IDLE state writes sample into the pending register and sets pending_valid. A later start overwrites it (latest wins).
- A start on the same edge that exits LDAC counts as pending; the next frame begins with no idle gap.
- busy is high from the cycle after acceptance until the cycle done pulses with no pending sample.
- Reset mid-operation forces idle outputs immediately and clears pending. The MCP4921 discards the partial frame because cs_n rises with fewer than 16 clocks. No done and no LDAC pulse are produced.
- The bit counter is 4 bits and the phase counter is sized for CLK_DIV-1. Neither wraps inside a phase.

## Timing
- Acceptance at edge k: cs_n=0, busy=1 from cycle k+1.
- cs_n low duration: 34H cycles (CS_SETUP + 32H SHIFT + CS_HOLD).
- ldac_n low duration: H cycles, starting the cycle cs_n returns high.
- done at cycle k+1+35H. Total write occupancy: 35H cycles (140 at H=4).
- sck period: 2H cycles, 50% duty; exactly 16 rising edges per frame.
- sdi changes only while sck=0. Setup to each rising edge is H cycles; hold after the edge is H cycles.

## Test plan
- Reset: assert reset mid-idle and mid-frame -> sck=0, sdi=0, cs_n=1, ldac_n=1, busy=0, done=0 asynchronously.
- Single write, H=4, sample=12'hA5C -> bench SPI model captures 16'h3A5C on 16 rising sck edges. cs_n low for 136 cycles, then ldac_n low for 4 cycles, done at acceptance+141, busy high for 140 cycles.
- Back-to-back: start 12'h123, then during its frame start 12'h456 and 12'h789 -> frames 16'h3123 then 16'h3789. done pulses twice, busy never drops between frames, 12'h456 is never sent.
- Reset after the 8th rising sck edge -> outputs idle immediately, pending cleared, no done and no ldac_n pulse. A following start of 12'h0F0 sends a clean 16'h30F0.
- Boundaries with CLK_DIV=1, BUF=1, GAIN_1X=0: samples 12'h000 and 12'hFFF -> frames 16'h5000 and 16'h5FFF, sck period 2 cycles, occupancy 35 cycles each.
- Start coincident with LDAC exit: start 12'h3FF on that edge -> done pulses and the next frame begins with no IDLE cycle and busy held high.
